// File: rtl/pio_input_pkg.sv
// rtl/pio_input_pkg.sv - register map, edge-mode and STATUS field constants for pio_input_capture
package pio_input_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA     = 2'd0,
        ADDR_IRQ_MASK = 2'd1,
        ADDR_EDGE_CAP = 2'd2,
        ADDR_STATUS   = 2'd3
    } pio_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int STATUS_IRQ_BIT  = 0;
    localparam int STATUS_PEND_BIT = 1;
    localparam int STATUS_SYNC_LSB = 8;
    localparam int STATUS_SYNC_W   = 8;

    // Clocks after reset release before an edge may be captured: the
    // synchronizer and any filter must first settle on the real input level.
    function automatic int arm_cycles(input int sync_stages, input int filt_cycles);
        return sync_stages + filt_cycles + 1;
    endfunction

endpackage

// File: rtl/pio_input_capture_if.sv
// rtl/pio_input_capture_if.sv - Avalon-MM slave register bus plus irq for pio_input_capture
interface pio_input_capture_if #(
    parameter int WIDTH = 32
) ();
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;
    logic             irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/pio_input_debounce.sv
// rtl/pio_input_debounce.sv - one-bit stability filter; output follows input after CYCLES stable clocks
module pio_input_debounce #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);
    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt;

    // Counter runs only while din disagrees with dout; any agreement restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt >= CW'(CYCLES - 1)) begin
            dout <= din;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/pio_input_capture.sv
// rtl/pio_input_capture.sv - synchronized PIO input with sticky edge capture and maskable irq; optional filter under PIO_INPUT_CAPTURE_DEBOUNCE_EN
module pio_input_capture
    import pio_input_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_MODE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     in_port,
    pio_input_capture_if.slave   bus
);
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] filt_in;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] ec_clr;
    logic [WIDTH-1:0] status;
    logic             wr_en;
    logic             irq_int;
    logic             armed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef PIO_INPUT_CAPTURE_DEBOUNCE_EN
    localparam int FILT_CYCLES = DEBOUNCE_CYCLES;

    for (genvar g = 0; g < WIDTH; g++) begin : g_debounce
        pio_input_debounce #(
            .CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (sync_in[g]),
            .dout    (filt_in[g])
        );
    end
`else
    // No filter in this build, so it adds no settling time.
    localparam int FILT_CYCLES = 0 * DEBOUNCE_CYCLES;

    assign filt_in = sync_in;
`endif

    localparam int ARM_CYCLES = arm_cycles(SYNC_STAGES, FILT_CYCLES);
    localparam int ACW        = $clog2(ARM_CYCLES + 1);

    logic [ACW-1:0] arm_cnt;

    // Hold edges off until the input pipeline has flushed its reset zeros,
    // otherwise a line already high at reset exit would look like a rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt <= '0;
            armed   <= 1'b0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + 1'b1;
            armed   <= (arm_cnt == ACW'(ARM_CYCLES - 1));
        end
    end

    always_comb begin
        edge_sel = filt_in & ~prev;
        if (EDGE_MODE == EDGE_FALL) begin
            edge_sel = ~filt_in & prev;
        end else if (EDGE_MODE == EDGE_ANY) begin
            edge_sel = filt_in ^ prev;
        end
        edge_det = armed ? edge_sel : '0;
    end

    assign wr_en  = bus.chipselect & ~bus.write_n;
    assign ec_clr = (wr_en && bus.address == ADDR_EDGE_CAP) ? bus.writedata : '0;

    // Set dominates clear when an edge lands in the same cycle as the W1C write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev         <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
        end else begin
            prev         <= filt_in;
            edge_capture <= (edge_capture & ~ec_clr) | edge_det;
            if (wr_en && bus.address == ADDR_IRQ_MASK) begin
                irq_mask <= bus.writedata;
            end
        end
    end

    assign irq_int = |(edge_capture & irq_mask);
    assign bus.irq = irq_int;

    localparam logic [STATUS_SYNC_W-1:0] SYNC_FIELD = STATUS_SYNC_W'(SYNC_STAGES);

    always_comb begin
        status                  = '0;
        status[STATUS_IRQ_BIT]  = irq_int;
        status[STATUS_PEND_BIT] = (edge_capture != '0);
        for (int i = 0; i < STATUS_SYNC_W; i++) begin
            if (STATUS_SYNC_LSB + i < WIDTH) status[STATUS_SYNC_LSB + i] = SYNC_FIELD[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            case (pio_addr_e'(bus.address))
                ADDR_DATA:     bus.readdata <= filt_in;
                ADDR_IRQ_MASK: bus.readdata <= irq_mask;
                ADDR_EDGE_CAP: bus.readdata <= edge_capture;
                default:       bus.readdata <= status;
            endcase
        end
    end
endmodule

// File: tb/tb_pio_input_capture.sv
// tb/tb_pio_input_capture.sv - randomized and directed bench for pio_input_capture (rise and any-edge instances)
module tb_pio_input_capture;
    import pio_input_pkg::*;

    localparam int W = 32;
    localparam int S = 2;
    localparam int D = 16;
`ifdef PIO_INPUT_CAPTURE_DEBOUNCE_EN
    localparam int FILT = D;
`else
    localparam int FILT = 0;
`endif
    localparam int ARM = S + FILT + 1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] in_port = '0;

    always #5 clk = ~clk;

    pio_input_capture_if #(.WIDTH(W)) bus_r ();
    pio_input_capture_if #(.WIDTH(W)) bus_a ();

    pio_input_capture #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_MODE(EDGE_RISE), .DEBOUNCE_CYCLES(D)) u_dut_rise (
        .clk (clk), .reset_n (reset_n), .in_port (in_port), .bus (bus_r)
    );
    pio_input_capture #(.WIDTH(W), .SYNC_STAGES(S), .EDGE_MODE(EDGE_ANY), .DEBOUNCE_CYCLES(D)) u_dut_any (
        .clk (clk), .reset_n (reset_n), .in_port (in_port), .bus (bus_a)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: index 0 = rising-edge instance, 1 = any-edge instance.
    logic [W-1:0] pipe [$];
    logic [W-1:0] m_prev, m_filt, m_mask;
    logic [W-1:0] m_ec [2];
    logic [W-1:0] m_rd [2];
    int           run  [W];
    int           m_cnt;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic m_irq(input int k);
        return |(m_ec[k] & m_mask);
    endfunction

    task automatic model_reset();
        pipe = {};
        for (int i = 0; i < S; i++) pipe.push_back('0);
        m_prev = '0; m_filt = '0; m_mask = '0; m_cnt = 0;
        for (int k = 0; k < 2; k++) begin m_ec[k] = '0; m_rd[k] = '0; end
        for (int i = 0; i < W; i++) run[i] = 0;
    endtask

    task automatic model_edge();
        logic [W-1:0] syn, f, rise, fall, clr, ev, st;
        logic         wr;
        syn  = pipe[S-1];
        f    = (FILT > 0) ? m_filt : syn;
        rise = f & ~m_prev;
        fall = ~f & m_prev;
        wr   = bus_r.chipselect && !bus_r.write_n;
        clr  = (wr && bus_r.address == 2'd2) ? bus_r.writedata : '0;
        for (int k = 0; k < 2; k++) begin
            st = '0;
            st[0] = m_irq(k);
            st[1] = (m_ec[k] != '0);
            st[15:8] = 8'(S);
            case (bus_r.address)
                2'd0:    m_rd[k] = f;
                2'd1:    m_rd[k] = m_mask;
                2'd2:    m_rd[k] = m_ec[k];
                default: m_rd[k] = st;
            endcase
            ev = '0;
            if (m_cnt >= ARM) ev = (k == 0) ? rise : (rise | fall);
            m_ec[k] = (m_ec[k] & ~clr) | ev;
        end
        if (wr && bus_r.address == 2'd1) m_mask = bus_r.writedata;
        m_prev = f;
        if (FILT > 0) begin
            for (int i = 0; i < W; i++) begin
                if (syn[i] != m_filt[i]) begin
                    run[i]++;
                    if (run[i] == FILT) begin m_filt[i] = syn[i]; run[i] = 0; end
                end else begin
                    run[i] = 0;
                end
            end
        end
        pipe.push_front(in_port);
        void'(pipe.pop_back());
        m_cnt++;
    endtask

    task automatic check_outputs();
        chk("rd_rise",  bus_r.readdata, m_rd[0]);
        chk("rd_any",   bus_a.readdata, m_rd[1]);
        chk("irq_rise", W'(bus_r.irq), W'(m_irq(0)));
        chk("irq_any",  W'(bus_a.irq), W'(m_irq(1)));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_bus(input logic cs, input logic wn, input logic [1:0] a, input logic [W-1:0] d);
        bus_r.chipselect = cs; bus_r.write_n = wn; bus_r.address = a; bus_r.writedata = d;
        bus_a.chipselect = cs; bus_a.write_n = wn; bus_a.address = a; bus_a.writedata = d;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [W-1:0] d);
        set_bus(1'b1, 1'b0, a, d);
        tick();
        set_bus(1'b0, 1'b1, a, '0);
    endtask

    task automatic bus_read(input logic [1:0] a);
        set_bus(1'b1, 1'b1, a, '0);
        tick();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] snap;
        set_bus(1'b0, 1'b1, 2'd0, '0);
        in_port = '1;
        model_reset();
        @(negedge clk);
        check_outputs();
        repeat (2) tick();
        reset_n = 1'b1;

        // Input high through reset: no false capture, DATA follows after the sync delay.
        repeat (ARM + 2) tick();
        bus_read(ADDR_EDGE_CAP);
        chk("t1_ec_rise", bus_r.readdata, '0);
        chk("t1_ec_any",  bus_a.readdata, '0);
        bus_read(ADDR_DATA);
        chk("t1_data", bus_r.readdata, 32'hFFFF_FFFF);
        chk("t1_irq",  W'(bus_r.irq), '0);

        // Single rise on bit3 with mask 0x8.
        in_port = '0;
        repeat (ARM + 1) tick();
        bus_write(ADDR_EDGE_CAP, '1);
        bus_write(ADDR_IRQ_MASK, 32'h8);
        in_port[3] = 1'b1;
        repeat (ARM - 1) tick();
        chk("t2_irq_early", W'(bus_r.irq), '0);
        tick();
        chk("t2_irq", W'(bus_r.irq), 32'h1);
        bus_read(ADDR_EDGE_CAP);
        chk("t2_ec", bus_r.readdata, 32'h8);
        bus_read(ADDR_STATUS);
        chk("t2_status", bus_r.readdata, 32'h0203);

        // Clear arriving in the same cycle as a fresh edge: the set wins.
        in_port[3] = 1'b0;
        repeat (ARM + 1) tick();
        bus_write(ADDR_EDGE_CAP, 32'h8);
        chk("t3_irq_cleared", W'(bus_r.irq), '0);
        in_port[3] = 1'b1;
        repeat (ARM - 1) tick();
        bus_write(ADDR_EDGE_CAP, 32'h8);
        chk("t3_irq_set_wins", W'(bus_r.irq), 32'h1);
        bus_read(ADDR_EDGE_CAP);
        chk("t3_ec_set_wins", bus_r.readdata, 32'h8);
        bus_write(ADDR_EDGE_CAP, 32'h8);
        chk("t3_irq_clean_clr", W'(bus_r.irq), '0);
        bus_read(ADDR_EDGE_CAP);
        chk("t3_ec_clean_clr", bus_r.readdata, '0);

        // Any-edge: two toggles on bit0 with mask 0, then unmask.
        bus_write(ADDR_IRQ_MASK, '0);
        bus_write(ADDR_EDGE_CAP, '1);
        in_port[0] = 1'b1;
        repeat (FILT + 4) tick();
        in_port[0] = 1'b0;
        repeat (ARM + 2) tick();
        bus_read(ADDR_EDGE_CAP);
        chk("t4_ec_any", bus_a.readdata, 32'h1);
        chk("t4_irq_masked", W'(bus_a.irq), '0);
        bus_write(ADDR_IRQ_MASK, 32'h1);
        chk("t4_irq_unmasked", W'(bus_a.irq), 32'h1);

        // Mask readback latency and DATA write immunity.
        bus_write(ADDR_IRQ_MASK, 32'hA5A5_0000);
        bus_read(ADDR_IRQ_MASK);
        chk("t5_mask_rd", bus_r.readdata, 32'hA5A5_0000);
        snap = in_port;
        bus_write(ADDR_DATA, ~snap);
        bus_read(ADDR_DATA);
        chk("t5_data_ro", bus_r.readdata, snap);

`ifdef PIO_INPUT_CAPTURE_DEBOUNCE_EN
        bus_write(ADDR_EDGE_CAP, '1);
        in_port[5] = 1'b1;
        repeat (10) tick();
        in_port[5] = 1'b0;
        repeat (ARM + 4) tick();
        bus_read(ADDR_EDGE_CAP);
        chk("t6_glitch", bus_r.readdata, '0);
        in_port[5] = 1'b1;
        repeat (20) tick();
        in_port[5] = 1'b0;
        repeat (ARM + 4) tick();
        bus_read(ADDR_EDGE_CAP);
        chk("t6_pulse", bus_r.readdata, 32'h20);
`endif

        // Randomized traffic with one asynchronous reset in the middle.
        for (int it = 0; it < 1500; it++) begin
            int op;
            if (it == 700) do_reset();
            if ($urandom_range(0, 3) == 0) in_port[$urandom_range(0, W-1)] ^= 1'b1;
            if ($urandom_range(0, 63) == 0) in_port = $urandom();
            op = $urandom_range(0, 3);
            case (op)
                0:       set_bus(1'b0, 1'b1, 2'($urandom_range(0, 3)), '0);
                1:       set_bus(1'b1, 1'b1, 2'($urandom_range(0, 3)), $urandom());
                2:       set_bus(1'b1, 1'b0, 2'($urandom_range(0, 3)), $urandom());
                default: set_bus(1'b0, 1'b0, 2'($urandom_range(0, 3)), $urandom());
            endcase
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
